// File: rtl/fetch_align_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pkg
//  Description : Shared constants and helpers for the fetch-align receive
//                path (lane geometry, tag width, default NOP, RVC test).
//  Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

  localparam int LANE_W = 16;                  // one instruction parcel
  localparam int LANE_N = 4;                   // parcels per SRAM word
  localparam int WORD_W = LANE_W * LANE_N;     // 64-bit SRAM word
  localparam int TAG_W  = 29;                  // word address bits [31:3]

  localparam logic [31:0] NOP_INSTR_DFLT = 32'h0000_0013;  // addi x0,x0,0

  // A parcel starts a compressed instruction unless its low two bits are 11.
  function automatic logic is_rvc(input logic [LANE_W-1:0] hw);
    return (hw & 16'h0003) != 16'h0003;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_align_if.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_align_if
//  Description : Bundle between the instruction SRAM return path / fetch
//                stage and fetch_align.
//                master : drives SRAM return, pc and redirect/flush, reads
//                         the extracted instruction.
//                slave  : fetch_align side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fetch_align_if;
  import fetch_pkg::*;

  logic                 isram_cs_ff;    // read data valid this cycle
  logic [TAG_W-1:0]     isram_adr_ff;   // word address [31:3] of rdata
  logic [WORD_W-1:0]    isram_rdata;    // returned word, lane k = [16k+15:16k]
  logic [31:0]          pc;             // address being fetched
  logic                 jb_ff;          // redirect issued last cycle
  logic                 fet_flush;      // drop everything incl. this return
  logic [31:0]          rv32_instr;     // extracted instruction
  logic                 isrv16;         // instruction is compressed
  logic                 inst_valid;     // rv32_instr complete and tag-correct
  logic                 fetch_misalign; // pc[0] set
  logic                 cross_wait;     // waiting for the second word

  modport master (
    output isram_cs_ff, isram_adr_ff, isram_rdata, pc, jb_ff, fet_flush,
    input  rv32_instr, isrv16, inst_valid, fetch_misalign, cross_wait
  );

  modport slave (
    input  isram_cs_ff, isram_adr_ff, isram_rdata, pc, jb_ff, fet_flush,
    output rv32_instr, isrv16, inst_valid, fetch_misalign, cross_wait
  );

endinterface
`default_nettype wire

// File: rtl/fetch_linebuf.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_linebuf
//  Description : Two-entry fetch buffer. CUR keeps the last captured 64-bit
//                word; HI keeps lane 3 of the word before it so a 32-bit
//                instruction straddling an 8-byte boundary can be stitched.
//                Also presents the word source W (returning word bypassed
//                with zero latency, else CUR).
//  Ports       : clk, cpurst          - clock, async active-high reset
//                cs_i/adr_i/rdata_i   - SRAM return (valid, tag, data)
//                jb_i, flush_i        - redirect / flush
//                w_*_o                - selected word source W
//                hi_*_o               - HI entry (masked by jb/flush)
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_linebuf
  import fetch_pkg::*;
(
  input  wire logic              clk,
  input  wire logic              cpurst,
  input  wire logic              cs_i,
  input  wire logic [TAG_W-1:0]  adr_i,
  input  wire logic [WORD_W-1:0] rdata_i,
  input  wire logic              jb_i,
  input  wire logic              flush_i,
  output logic                   w_vld_o,
  output logic [TAG_W-1:0]       w_tag_o,
  output logic [WORD_W-1:0]      w_data_o,
  output logic                   hi_vld_o,
  output logic [TAG_W-1:0]       hi_tag_o,
  output logic [LANE_W-1:0]      hi_half_o
);

  logic              cur_vld_q, cur_vld_d;
  logic [TAG_W-1:0]  cur_tag_q, cur_tag_d;
  logic [WORD_W-1:0] cur_data_q, cur_data_d;
  logic              hi_vld_q, hi_vld_d;
  logic [TAG_W-1:0]  hi_tag_q, hi_tag_d;
  logic [LANE_W-1:0] hi_half_q, hi_half_d;

  logic capture;
  logic buf_ok;   // buffered entries usable this cycle

  assign capture = cs_i & ~flush_i;
  assign buf_ok  = ~jb_i & ~flush_i;

  always_comb begin
    cur_vld_d  = cur_vld_q;
    cur_tag_d  = cur_tag_q;
    cur_data_d = cur_data_q;
    hi_vld_d   = hi_vld_q;
    hi_tag_d   = hi_tag_q;
    hi_half_d  = hi_half_q;
    if (flush_i) begin
      cur_vld_d = 1'b0;
      hi_vld_d  = 1'b0;
    end else begin
      // Age the old word into HI only on a sequential (non-redirect) capture.
      if (capture && !jb_i && cur_vld_q) begin
        hi_vld_d  = 1'b1;
        hi_tag_d  = cur_tag_q;
        hi_half_d = cur_data_q[WORD_W-1 -: LANE_W];
      end
      if (jb_i) begin
        hi_vld_d  = 1'b0;
        cur_vld_d = capture;
      end
      if (capture) begin
        cur_vld_d  = 1'b1;
        cur_tag_d  = adr_i;
        cur_data_d = rdata_i;
      end
    end
  end

  always_ff @(posedge clk or posedge cpurst) begin
    if (cpurst) begin
      cur_vld_q <= 1'b0;
      hi_vld_q  <= 1'b0;
    end else begin
      cur_vld_q <= cur_vld_d;
      hi_vld_q  <= hi_vld_d;
    end
  end

  // Payload fields are qualified by the valid bits and need no reset.
  always_ff @(posedge clk) begin
    cur_tag_q  <= cur_tag_d;
    cur_data_q <= cur_data_d;
    hi_tag_q   <= hi_tag_d;
    hi_half_q  <= hi_half_d;
  end

  // Word source: the returning word wins over CUR (zero-cycle bypass).
  assign w_vld_o   = capture | (cur_vld_q & buf_ok);
  assign w_tag_o   = capture ? adr_i   : cur_tag_q;
  assign w_data_o  = capture ? rdata_i : cur_data_q;
  assign hi_vld_o  = hi_vld_q & buf_ok;
  assign hi_tag_o  = hi_tag_q;
  assign hi_half_o = hi_half_q;

endmodule
`default_nettype wire

// File: rtl/fetch_align.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_align
//  Description : Instruction extraction at the fetch pc from 64-bit SRAM
//                words, handling RV16/RV32 forms and stitching RV32
//                instructions that straddle an 8-byte boundary.
//  Ports       : clk          - core clock
//                cpurst       - async active-high reset
//                bus (slave)  - SRAM return, pc, jb_ff, fet_flush in;
//                               rv32_instr, isrv16, inst_valid,
//                               fetch_misalign, cross_wait out
//  Parameters  : NOP_INSTR    - rv32_instr value while inst_valid=0
//                REG_OUT      - 1 registers all outputs (+1 cycle)
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_align
  import fetch_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DFLT,
  parameter bit          REG_OUT   = 1'b0
) (
  input  wire logic     clk,
  input  wire logic     cpurst,
  fetch_align_if.slave  bus
);

  logic              w_vld;
  logic [TAG_W-1:0]  w_tag;
  logic [WORD_W-1:0] w_data;
  logic              hi_vld;
  logic [TAG_W-1:0]  hi_tag;
  logic [LANE_W-1:0] hi_half;

  fetch_linebuf u_linebuf (
    .clk       (clk),
    .cpurst    (cpurst),
    .cs_i      (bus.isram_cs_ff),
    .adr_i     (bus.isram_adr_ff),
    .rdata_i   (bus.isram_rdata),
    .jb_i      (bus.jb_ff),
    .flush_i   (bus.fet_flush),
    .w_vld_o   (w_vld),
    .w_tag_o   (w_tag),
    .w_data_o  (w_data),
    .hi_vld_o  (hi_vld),
    .hi_tag_o  (hi_tag),
    .hi_half_o (hi_half)
  );

  logic [TAG_W-1:0]  t_tag, t1_tag;
  logic [1:0]        off;
  logic              w_hit, w_nxt, hi_hit;
  logic [LANE_W-1:0] lane_lo, lane_nx, lo_half;

  assign t_tag  = bus.pc[31:3];
  assign t1_tag = t_tag + TAG_W'(1);     // wraps to 0 at all-ones
  assign off    = bus.pc[2:1];
  assign w_hit  = w_vld  && (w_tag  == t_tag);
  assign w_nxt  = w_vld  && (w_tag  == t1_tag);
  assign hi_hit = hi_vld && (hi_tag == t_tag);

  // Lane after 'off' wraps 3 -> 0, which is exactly the T1 high half.
  assign lane_lo = w_data[{off, 4'd0} +: LANE_W];
  assign lane_nx = w_data[{off + 2'd1, 4'd0} +: LANE_W];

  logic [31:0] instr_c;
  logic        rvc_c, vld_c, mis_c, cw_c;

  always_comb begin
    instr_c = NOP_INSTR;
    rvc_c   = 1'b0;
    vld_c   = 1'b0;
    cw_c    = 1'b0;
    mis_c   = bus.pc[0];
    lo_half = w_hit ? lane_lo : hi_half;
    if (!bus.pc[0]) begin
      if (off != 2'd3) begin
        if (w_hit) begin
          vld_c = 1'b1;
          rvc_c = is_rvc(lo_half);
        end
      end else if (w_hit || hi_hit) begin
        if (is_rvc(lo_half)) begin
          vld_c = 1'b1;
          rvc_c = 1'b1;
        end else if (w_nxt) begin
          vld_c = 1'b1;
        end else begin
          cw_c = 1'b1;
        end
      end else begin
        // Second word already here but the first half was lost: refetch T.
        cw_c = w_nxt;
      end
    end
    if (vld_c) begin
      instr_c = rvc_c ? {16'h0000, lo_half} : {lane_nx, lo_half};
    end
  end

  generate
    if (REG_OUT) begin : g_reg_out
      logic [31:0] instr_q;
      logic        rvc_q, vld_q, mis_q, cw_q;

      always_ff @(posedge clk or posedge cpurst) begin
        if (cpurst) begin
          instr_q <= NOP_INSTR;
          rvc_q   <= 1'b0;
          vld_q   <= 1'b0;
          mis_q   <= 1'b0;
          cw_q    <= 1'b0;
        end else begin
          instr_q <= instr_c;
          rvc_q   <= rvc_c;
          vld_q   <= vld_c;
          mis_q   <= mis_c;
          cw_q    <= cw_c;
        end
      end

      assign bus.rv32_instr     = instr_q;
      assign bus.isrv16         = rvc_q;
      assign bus.inst_valid     = vld_q;
      assign bus.fetch_misalign = mis_q;
      assign bus.cross_wait     = cw_q;
    end else begin : g_comb_out
      // Force reset values while cpurst is asserted so a reset mid-stitch
      // cannot leak a bypassed word to the PC generator.
      assign bus.rv32_instr     = cpurst ? NOP_INSTR : instr_c;
      assign bus.isrv16         = rvc_c & ~cpurst;
      assign bus.inst_valid     = vld_c & ~cpurst;
      assign bus.fetch_misalign = mis_c & ~cpurst;
      assign bus.cross_wait     = cw_c  & ~cpurst;
    end
  endgenerate

endmodule
`default_nettype wire
